// File: rtl/mc_ctrl_pkg.sv
//------------------------------------------------------------------------------
// mc_ctrl_pkg : opcode/func constants, state encodings and datapath select codes
//               shared by the multi-cycle MIPS-lite control sequencer.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mc_ctrl_pkg;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_ori   = 6'h0d;
  localparam logic [5:0] c_op_lui   = 6'h0f;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2b;
  localparam logic [5:0] c_op_bsoal = 6'h3f;

  localparam logic [5:0] c_fn_jr  = 6'h08;
  localparam logic [5:0] c_fn_add = 6'h20;
  localparam logic [5:0] c_fn_sub = 6'h22;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [1:0] c_npc_pc4    = 2'd0;
  localparam logic [1:0] c_npc_jump   = 2'd1;
  localparam logic [1:0] c_npc_branch = 2'd2;
  localparam logic [1:0] c_npc_jr     = 2'd3;

  localparam logic [1:0] c_dst_rt = 2'd0;
  localparam logic [1:0] c_dst_rd = 2'd1;
  localparam logic [1:0] c_dst_ra = 2'd2;

  localparam logic [1:0] c_m2r_alu  = 2'd0;
  localparam logic [1:0] c_m2r_dm   = 2'd1;
  localparam logic [1:0] c_m2r_link = 2'd2;

  localparam logic [2:0] c_alu_add = 3'd0;
  localparam logic [2:0] c_alu_sub = 3'd1;
  localparam logic [2:0] c_alu_or  = 3'd2;
  localparam logic [2:0] c_alu_lui = 3'd3;

  // Exactly one field is set for any op/func pair.
  typedef struct packed {
    logic add;
    logic sub;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic bsoal;
    logic ill;
  } instr_cls_t;

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
//------------------------------------------------------------------------------
// mc_ctrl_decode : combinational op/func -> one-hot instruction class.
//                  BSOAL_CTRL_EN makes op 6'b111111 (bsoal) legal.
// Revision       : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output instr_cls_t o_cls
);

  always_comb begin
    o_cls = '0;
    case (i_op)
      c_op_rtype: begin
        case (i_func)
          c_fn_add: o_cls.add = 1'b1;
          c_fn_sub: o_cls.sub = 1'b1;
          c_fn_jr:  o_cls.jr  = 1'b1;
          default:  o_cls.ill = 1'b1;
        endcase
      end
      c_op_ori: o_cls.ori = 1'b1;
      c_op_lui: o_cls.lui = 1'b1;
      c_op_lw:  o_cls.lw  = 1'b1;
      c_op_sw:  o_cls.sw  = 1'b1;
      c_op_beq: o_cls.beq = 1'b1;
      c_op_j:   o_cls.j   = 1'b1;
      c_op_jal: o_cls.jal = 1'b1;
`ifdef BSOAL_CTRL_EN
      c_op_bsoal: o_cls.bsoal = 1'b1;
`endif
      default:  o_cls.ill = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
//------------------------------------------------------------------------------
// mc_ctrl_fsm : multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with
//               DM timeout and retired-instruction counter (BSOAL_CTRL_EN option).
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             cmp_eq,
  input  logic             b_parity,
  input  logic             mem_ready,
  output logic             ir_we,
  output logic             ab_we,
  output logic             pc_we,
  output logic [1:0]       npc_op,
  output logic             br_take,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             ext_op,
  output logic             alu_src,
  output logic [2:0]       alu_ctrl,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_err,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  // r_wait counts completed MEM cycles, so the abort lands on MEM cycle MEM_TIMEOUT.
  localparam logic [7:0] c_wait_last = 8'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [7:0]       r_wait;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  instr_cls_t       w_cls;

  mc_ctrl_decode u_decode (
    .i_op   (op),
    .i_func (func),
    .o_cls  (w_cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_wait    <= 8'd0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nx;
      r_wait  <= (r_state == S_MEM) ? r_wait + 8'd1 : 8'd0;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nx = S_FETCH;
    w_retire   = 1'b0;
    ir_we      = 1'b0;
    ab_we      = 1'b0;
    pc_we      = 1'b0;
    npc_op     = c_npc_pc4;
    br_take    = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = c_dst_rt;
    mem_to_reg = c_m2r_alu;
    ext_op     = 1'b0;
    alu_src    = 1'b0;
    alu_ctrl   = c_alu_add;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_err    = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      // ALU controls stay put through MEM/WB so the address and result hold steady.
      if (r_state inside {S_EXEC, S_MEM, S_WB}) begin
        alu_src = w_cls.ori | w_cls.lui | w_cls.lw | w_cls.sw;
        ext_op  = w_cls.lw | w_cls.sw | w_cls.beq;
        if (w_cls.sub | w_cls.beq) alu_ctrl = c_alu_sub;
        else if (w_cls.ori)        alu_ctrl = c_alu_or;
        else if (w_cls.lui)        alu_ctrl = c_alu_lui;
      end
      case (r_state)
        S_FETCH: begin
          ir_we      = 1'b1;
          w_state_nx = S_DECODE;
        end
        S_DECODE: begin
          ab_we = 1'b1;
          if (w_cls.j | w_cls.jal) begin
            pc_we    = 1'b1;
            npc_op   = c_npc_jump;
            w_retire = 1'b1;
            if (w_cls.jal) begin
              reg_we     = 1'b1;
              reg_dst    = c_dst_ra;
              mem_to_reg = c_m2r_link;
            end
          end else if (w_cls.jr) begin
            pc_we    = 1'b1;
            npc_op   = c_npc_jr;
            w_retire = 1'b1;
          end else if (w_cls.ill) begin
            illegal = 1'b1;
            pc_we   = 1'b1;
          end else begin
            w_state_nx = S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_cls.beq) begin
            pc_we    = 1'b1;
            npc_op   = c_npc_branch;
            br_take  = cmp_eq;
            w_retire = 1'b1;
          end else if (w_cls.bsoal) begin
            pc_we      = 1'b1;
            npc_op     = c_npc_branch;
            br_take    = b_parity;
            reg_we     = b_parity;
            reg_dst    = c_dst_ra;
            mem_to_reg = c_m2r_link;
            w_retire   = 1'b1;
          end else if (w_cls.lw | w_cls.sw) begin
            w_state_nx = S_MEM;
          end else begin
            w_state_nx = S_WB;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = w_cls.sw;
          if (mem_ready) begin
            if (w_cls.sw) begin
              pc_we    = 1'b1;
              w_retire = 1'b1;
            end else begin
              w_state_nx = S_WB;
            end
          end else if (r_wait == c_wait_last) begin
            mem_err = 1'b1;
            pc_we   = 1'b1;
          end else begin
            w_state_nx = S_MEM;
          end
        end
        S_WB: begin
          reg_we   = 1'b1;
          pc_we    = 1'b1;
          w_retire = 1'b1;
          if (w_cls.lw)                  mem_to_reg = c_m2r_dm;
          else if (w_cls.add | w_cls.sub) reg_dst   = c_dst_rd;
        end
        default: ;
      endcase
    end
  end

  assign retired = r_retired;
  assign state   = r_state;

endmodule

`default_nettype wire
